tree_sum_accumulator: RTL and testbench

TREE_SUM_ACCUMULATOR -- requirements
Module: tree_sum_accumulator

---
 rtl/tree_acc_pkg.sv | 14 +
 rtl/tree_sum_accumulator.sv | 108 ++++++++++
 tb/tb_tree_sum_accumulator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tree_acc_pkg.sv
// Shared types and default widths for the tree-sum accumulator.
package tree_acc_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned ACC_W_DEF = 48;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/tree_sum_accumulator.sv
// Sums cfg_len signed beats from the tree adder into one wide result,
// held with valid/ready until the consumer takes it.
module tree_sum_accumulator
  import tree_acc_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;

  state_t           w_state_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic             w_in_ready;

  logic [ACC_W-1:0] w_sext;
  logic [CNT_W-1:0] w_len_first;
  state_t           w_first_state;
  logic [CNT_W-1:0] w_cnt_inc;

  // A zero length is treated as a single-beat frame.
  assign w_sext        = ACC_W'($signed(in_data));
  assign w_len_first   = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  assign w_first_state = (w_len_first == CNT_W'(1)) ? ST_HOLD : ST_ACC;
  assign w_cnt_inc     = r_cnt + CNT_W'(1);

  // Next-state, datapath update and input handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_in_ready  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_len_nxt   = w_len_first;
          w_acc_nxt   = w_sext;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = w_first_state;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          w_acc_nxt = r_acc + w_sext;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A new frame may start on the same cycle the result is taken.
        w_in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_len_nxt   = w_len_first;
            w_acc_nxt   = w_sext;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = w_first_state;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= CNT_W'(1);
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_acc;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Self-checking bench for tree_sum_accumulator: directed scenarios plus a
// randomized run against a frame-level sum model.
module tb_tree_sum_accumulator;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_len;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks;
  int n_fail;

  tree_sum_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic [7:0] cfg);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    cfg_len   = cfg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'd77, 1'b1, 8'd1);
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (out_data !== 48'd0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 8'd1);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_sum();
    int beats [4];
    beats = '{36, -4, 0, 183};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(beats[i]), 1'b1, 8'd4);
      tick();
      if (i < 3) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid beat %0d got %b want 0", i, out_valid); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_checks++;
    if (out_data !== 48'd215) begin n_fail++; $display("FAIL basic_data got %0d want 215", $signed(out_data)); end
    drive(1'b0, 32'd0, 1'b1, 8'd4);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_len_zero();
    drive(1'b1, 32'd5, 1'b1, 8'd0);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 48'd5) begin
      n_fail++; $display("FAIL len0_first valid=%b data=%0d want 1 5", out_valid, $signed(out_data));
    end
    drive(1'b1, 32'(-7), 1'b1, 8'd0);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL len0_in_ready got %b want 1", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 48'(-7)) begin
      n_fail++; $display("FAIL len0_second valid=%b data=%0d want 1 -7", out_valid, $signed(out_data));
    end
    drive(1'b0, 32'd0, 1'b1, 8'd0);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'd10, 1'b0, 8'd2);
    tick();
    drive(1'b1, 32'd20, 1'b0, 8'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd99, 1'b0, 8'd2);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 48'd30) begin
        n_fail++; $display("FAIL bp_hold cyc %0d valid=%b data=%0d want 1 30", i, out_valid, $signed(out_data));
      end
      tick();
    end
    drive(1'b1, 32'd7, 1'b1, 8'd2);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || out_data !== 48'd7) begin
      n_fail++; $display("FAIL bp_newframe valid=%b busy=%b data=%0d want 0 1 7", out_valid, busy, $signed(out_data));
    end
    drive(1'b1, 32'd3, 1'b1, 8'd2);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 48'd10) begin
      n_fail++; $display("FAIL bp_second valid=%b data=%0d want 1 10", out_valid, $signed(out_data));
    end
    drive(1'b0, 32'd0, 1'b1, 8'd2);
    tick();
  endtask

  task automatic test_wide_sum();
    logic [47:0] exp_sum;
    exp_sum = 48'(-64'sd6442450944);
    drive(1'b1, 32'h8000_0000, 1'b1, 8'd3);
    tick();
    drive(1'b1, 32'h8000_0000, 1'b1, 8'd1);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wide_cfg_ignored valid got %b want 0", out_valid); end
    drive(1'b1, 32'h8000_0000, 1'b1, 8'd1);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_sum) begin
      n_fail++; $display("FAIL wide_sum valid=%b data=%0d want 1 %0d", out_valid, $signed(out_data), $signed(exp_sum));
    end
    drive(1'b0, 32'd0, 1'b1, 8'd1);
    tick();
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 32'd100, 1'b1, 8'd4);
    tick();
    drive(1'b1, 32'd200, 1'b1, 8'd4);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 8'd4);
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 48'd0) begin
      n_fail++; $display("FAIL midrst_state valid=%b busy=%b data=%0d want 0 0 0", out_valid, busy, $signed(out_data));
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd1, 1'b1, 8'd4);
      tick();
      if (i < 3) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stray_result beat %0d valid=%b want 0", i, out_valid); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 48'd4) begin
      n_fail++; $display("FAIL midrst_result valid=%b data=%0d want 1 4", out_valid, $signed(out_data));
    end
    drive(1'b0, 32'd0, 1'b1, 8'd4);
    tick();
  endtask

  // Model keeps the running frame sum as a plain integer and a flag for a
  // completed result awaiting the consumer.
  task automatic test_random_frames();
    longint m_acc;
    int     m_cnt;
    int     m_len;
    bit     m_pend;
    int     frames;
    int     cycles;
    logic   v;
    logic   ordy;
    int     d;
    int     cfg;
    bit     exp_ready;
    bit     beat;

    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 8'd1);
    tick();
    rst = 1'b0;
    m_acc = 0; m_cnt = 0; m_len = 1; m_pend = 0; frames = 0; cycles = 0;

    while (frames < 200 && cycles < 20000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = int'($urandom);
      cfg  = $urandom_range(1, 16);
      drive(v, 32'(d), ordy, 8'(cfg));
      #1;
      exp_ready = !m_pend || ordy;
      n_checks++;
      if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready cyc %0d got %b want %b", cycles, in_ready, exp_ready); end
      n_checks++;
      if (out_valid !== m_pend) begin n_fail++; $display("FAIL rand_out_valid cyc %0d got %b want %b", cycles, out_valid, m_pend); end
      n_checks++;
      if (out_data !== 48'(m_acc)) begin n_fail++; $display("FAIL rand_out_data cyc %0d got %0d want %0d", cycles, $signed(out_data), m_acc); end
      n_checks++;
      if (busy !== (m_pend || m_cnt != 0)) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b want %b", cycles, busy, (m_pend || m_cnt != 0)); end

      beat = v && exp_ready;
      if (m_pend && ordy) m_pend = 0;
      if (beat) begin
        if (m_cnt == 0) begin
          m_len = cfg;
          m_acc = longint'(d);
          m_cnt = 1;
        end else begin
          m_acc = m_acc + longint'(d);
          m_cnt++;
        end
        if (m_cnt == m_len) begin
          m_pend = 1;
          m_cnt  = 0;
          frames++;
        end
      end
      tick();
      cycles++;
    end
    n_checks++;
    if (frames < 200) begin n_fail++; $display("FAIL rand_timeout frames %0d want 200", frames); end
    drive(1'b0, 32'd0, 1'b1, 8'd1);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 8'd1);
    test_reset();
    test_basic_sum();
    test_len_zero();
    test_backpressure();
    test_wide_sum();
    test_reset_midframe();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
